// File: rtl/mdu_iter_pkg.sv
// Shared MDU encodings: op codes, FSM states and small op-class helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mdu_iter_pkg;

    // Op codes driven by aludec into the MDU.
    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    // FSM state encodings.
    localparam logic [1:0] MDU_ST_IDLE = 2'd0;
    localparam logic [1:0] MDU_ST_MUL  = 2'd1;
    localparam logic [1:0] MDU_ST_DIV  = 2'd2;
    localparam logic [1:0] MDU_ST_FIX  = 2'd3;

    // Ops that occupy the iterative datapath (and therefore stall the pipe).
    function automatic logic mdu_is_muldiv(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

    // Ops whose operands are two's-complement.
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_hilo_reg.sv
// HI/LO architectural register pair with independent write enables.
// Latency: write visible on hi_o/lo_o one edge after the enable.
// Backpressure: none; writes always accepted.
// Ports: clk, resetn (async active-low clear), hi/lo write enables and data, hi_o/lo_o.
module mdu_iter_hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hi_we_i,
    input  logic [WIDTH-1:0] hi_wd_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] lo_wd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we_i) hi_q <= hi_wd_i;
            if (lo_we_i) lo_q <= lo_wd_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit (1 bit/cycle) with HI/LO; MTHI/MTLO in one cycle.
// Latency: mul/div result in HI/LO and done pulse WIDTH+1 edges after the start edge.
// Backpressure: stall freezes IF..EX while busy; starts arriving while busy are dropped.
// Ports: clk, resetn, start/op/a/b request, flush abort; busy, done, stall, hi, lo.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}. DIV: low half shifts
    // dividend bits out at the top and quotient bits in at the bottom.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               done_q, done_d;

    logic               hi_we, lo_we;
    logic [WIDTH-1:0]   hi_wd, lo_wd;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, remv;

    assign op_signed = mdu_is_signed(op);
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // rem_q[WIDTH] is always 0 after a restore step; folding it into ge keeps
    // the compare correct even if it were not.
    assign shifted = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign ge      = rem_q[WIDTH] | (shifted >= {1'b0, opnd_q});

    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remv = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        done_d    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_wd     = '0;
        lo_wd     = '0;

        case (state_q)
            MDU_ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        MDU_OP_MTHI: begin
                            hi_we = 1'b1;
                            hi_wd = a;
                        end
                        MDU_OP_MTLO: begin
                            lo_we = 1'b1;
                            lo_wd = a;
                        end
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            state_d   = MDU_ST_MUL;
                            cnt_d     = '0;
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opnd_d    = a_mag;
                            neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            state_d   = MDU_ST_DIV;
                            cnt_d     = '0;
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            rem_d     = '0;
                            opnd_d    = b_mag;
                            // Divide by zero yields an all-ones quotient from the
                            // restoring loop; never negate it so lo stays all-ones.
                            neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
                            neg_rem_d = op_signed & a[WIDTH-1];
                            is_div_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MDU_ST_MUL: begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = MDU_ST_FIX;
            end
            MDU_ST_DIV: begin
                rem_d = ge ? (shifted - {1'b0, opnd_q}) : shifted;
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = MDU_ST_FIX;
            end
            default: begin // MDU_ST_FIX
                state_d = MDU_ST_IDLE;
                done_d  = 1'b1;
                hi_we   = 1'b1;
                lo_we   = 1'b1;
                if (is_div_q) begin
                    hi_wd = remv;
                    lo_wd = quo;
                end else begin
                    hi_wd = prod[2*WIDTH-1:WIDTH];
                    lo_wd = prod[WIDTH-1:0];
                end
            end
        endcase

        // Flush aborts any in-flight op, including its final write.
        if (flush && state_q != MDU_ST_IDLE) begin
            state_d = MDU_ST_IDLE;
            done_d  = 1'b0;
            hi_we   = 1'b0;
            lo_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= MDU_ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            done_q    <= done_d;
        end
    end

    mdu_iter_hilo_reg #(.WIDTH(WIDTH)) u_hilo_reg (
        .clk     (clk),
        .resetn  (resetn),
        .hi_we_i (hi_we),
        .hi_wd_i (hi_wd),
        .lo_we_i (lo_we),
        .lo_wd_i (lo_wd),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    assign busy  = (state_q != MDU_ST_IDLE);
    assign done  = done_q;
    assign stall = busy | (start & mdu_is_muldiv(op));

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural reference: what HI/LO must hold after the op retires.
    task automatic apply_model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] p;
        int          q, r;
        case (o)
            MDU_OP_MULT: begin
                p = longint'($signed(av)) * longint'($signed(bv));
                exp_hi = p[63:32]; exp_lo = p[31:0];
            end
            MDU_OP_MULTU: begin
                p = {32'd0, av} * {32'd0, bv};
                exp_hi = p[63:32]; exp_lo = p[31:0];
            end
            MDU_OP_DIV: begin
                if (bv == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF; exp_hi = av;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000; exp_hi = 32'd0;
                end else begin
                    q = $signed(av) / $signed(bv);
                    r = $signed(av) % $signed(bv);
                    exp_lo = q; exp_hi = r;
                end
            end
            MDU_OP_DIVU: begin
                if (bv == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF; exp_hi = av;
                end else begin
                    exp_lo = av / bv; exp_hi = av % bv;
                end
            end
            MDU_OP_MTHI: exp_hi = av;
            MDU_OP_MTLO: exp_lo = av;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and check stall, latency, busy span, done pulse and HI/LO.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        int  k;
        int  busy_n;
        int  stall_n;
        bit  md;
        md = (o <= MDU_OP_DIVU);
        apply_model(o, av, bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        #1 check("stall_on_req", {63'd0, stall}, {63'd0, md});
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        if (md) begin
            busy_n = 0; stall_n = 0;
            for (k = 1; k <= 100; k++) begin
                if (done) break;
                if (busy) busy_n++;
                if (stall) stall_n++;
                @(negedge clk);
            end
            check("latency", 64'(k - 1), 64'd33);
            check("busy_cycles", 64'(busy_n), 64'd33);
            check("stall_cycles", 64'(stall_n), 64'd33);
            check("hi", {32'd0, hi}, {32'd0, exp_hi});
            check("lo", {32'd0, lo}, {32'd0, exp_lo});
            @(negedge clk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
        end else begin
            check("mt_hi", {32'd0, hi}, {32'd0, exp_hi});
            check("mt_lo", {32'd0, lo}, {32'd0, exp_lo});
            check("mt_busy", {63'd0, busy}, 64'd0);
            check("mt_done", {63'd0, done}, 64'd0);
            check("mt_stall", {63'd0, stall}, 64'd0);
        end
    endtask

    // Start a MULT, optionally poke a start at cycle 5, flush at cycle kf.
    task automatic flush_at(input int kf);
        int done_n;
        int busy_n;
        @(negedge clk);
        start = 1'b1; op = MDU_OP_MULT; a = $urandom; b = $urandom;
        @(negedge clk);
        for (int k = 1; k < kf; k++) begin
            start = (k == 5); op = MDU_OP_DIV; a = $urandom; b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {63'd0, busy}, 64'd0);
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_n++;
            if (busy) busy_n++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(done_n), 64'd0);
        check("flush_no_requeue", 64'(busy_n), 64'd0);
        check("flush_hi", {32'd0, hi}, {32'd0, exp_hi});
        check("flush_lo", {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        resetn = 1'b1;

        // Directed cases
        run_op(MDU_OP_MULT,  32'hFFFF_FFFD, 32'd5);
        check("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFF1);
        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        run_op(MDU_OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mult_m1_lo", {32'd0, lo}, 64'd1);
        run_op(MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        run_op(MDU_OP_DIVU,  32'd7, 32'd2);
        run_op(MDU_OP_DIVU,  32'd7, 32'd0);
        check("divu_zero_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        run_op(MDU_OP_DIV,   32'hFFFF_FFF9, 32'd0);
        run_op(MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);

        // Flush mid-op and during FIX
        run_op(MDU_OP_MTHI, 32'h0000_1234, 32'd0);
        run_op(MDU_OP_MTLO, 32'h0000_5678, 32'd0);
        flush_at(10);
        flush_at(33);

        // MTHI/MTLO issued together with flush must not write
        @(negedge clk);
        start = 1'b1; op = MDU_OP_MTLO; a = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("mt_flush_lo", {32'd0, lo}, {32'd0, exp_lo});
        run_op(MDU_OP_MTHI, 32'hAAAA_5555, 32'd0);

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = MDU_OP_DIV; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        check("arst_done", {63'd0, done}, 64'd0);
        resetn = 1'b1;
        run_op(MDU_OP_MULTU, $urandom, $urandom);

        // Randomized ops with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 5)), rand_val(), rand_val());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
